pellet_eater: RTL
=================

# pellet_eater

Consumes pellets as pacman moves through the maze. It samples pacman's current 10-bit block address and reads the matching bit of a 32×32 pellet-map RAM. When a pellet is present, it clears that bit with a read-modify-write, adds points to the score and decrements the pellets-remaining count. It sits beside the movement FSM, takes the same position register as input, and drives the score and level-clear signals to the game controller and display.

## Interface
- PELLET_COUNT, default 300: pellets present in the map at power-up. Reset value of `pellets_left`.
- POINTS, default 10: points added per pellet eaten. Binary value, or the BCD-digit value when `SCORE_BCD_EN` is defined; must be < 100.
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  leaves idle on the first cycle it is high; ignored outside s_idle.
- pac_block  input  10  pacman block address, {row[4:0], col[4:0]}.
- ram_addr  output  5  pellet-map word address (row).
- ram_rdata  input  32  pellet-map read data, 1-cycle registered read latency; bit 31-col is the cell, 1 = pellet.
- ram_wdata  output  32  write-back word.
- ram_we  output  1  write enable, single-cycle pulse.
- score  output  16  running score.
- pellets_left  output  10  pellets remaining.
- eat_pulse  output  1  1-cycle pulse per pellet eaten.
- level_clear  output  1  high once pellets_left reaches 0; sticky until reset.
- busy  output  1  high in every state except s_idle and s_done.

## Operation
- States: s_idle, s_capture, s_read, s_wait, s_check, s_write, s_done.
- s_idle: goes to s_capture when start=1, otherwise stays.
- s_capture: latches pac_block into blk_reg, then goes to s_read.
- s_read: ram_addr = blk_reg[9:5], held stable through s_write. Goes to s_wait.
- s_wait: RAM data settles. Goes to s_check.
- s_check: registers word_reg = ram_rdata and sel = ram_rdata[31 - blk_reg[4:0]].
  - sel=1: goes to s_write and computes ram_wdata = ram_rdata with that bit cleared.
  - sel=0: goes back to s_capture.
- s_write: ram_we=1 for this cycle only.
  - score += POINTS, pellets_left -= 1, eat_pulse=1.
  - If pellets_left was 1, goes to s_done; otherwise goes to s_capture.
- s_done: level_clear=1. No RAM activity. Stays here until reset.
- Arithmetic:
  - score saturates at 16'hFFFF in binary mode (16'h9999 in BCD mode) and never wraps.
  - pellets_left never goes below 0.
- Pacman staying on an eaten cell: the bit reads 0, so there is no double count.
- pac_block changing between s_capture and s_write has no effect on the current pass; the new value is picked up at the next s_capture.
- Reset (reset=0) in any state, on the next edge:
  - state = s_idle; ram_we = 0, including during s_write (the write is aborted).
  - score = 0, pellets_left = PELLET_COUNT, eat_pulse = 0, level_clear = 0, ram_addr = 0, ram_wdata = 0, busy = 0.
- RAM contents are not restored by reset; that is the maze loader's job.

## Timing
- Pass length: 4 cycles without a pellet (capture, read, wait, check), 5 with a pellet (plus write).
- pac_block sampled at edge N (s_capture): ram_addr valid from cycle N+1, data used at the end of cycle N+3, ram_we high in cycle N+4.
- score, pellets_left and eat_pulse update on the edge ending s_write; all outputs are registered.
- level_clear rises on the same edge that pellets_left becomes 0.

## Configuration
- `SCORE_BCD_EN` defined:
  - score holds 4 packed BCD digits and the add is done as a decimal add with per-digit carry; POINTS is read as BCD.
  - Saturates at 9999.
- `SCORE_BCD_EN` undefined: plain binary add, saturating at 65535.

## Test plan
- Reset, then start with pac_block=10'd33 and word 1 = 32'h4000_0000.
  - ram_we pulses once with ram_wdata=0.
  - score=10, pellets_left=299, exactly one eat_pulse.
- Same cell held for 20 cycles after it is eaten -> no further ram_we; score stays 10.
- Empty cell (ram_rdata bit = 0) -> 4-cycle loop, ram_we never asserted, busy=1 throughout.
- PELLET_COUNT=2, eat two cells -> level_clear=1 and the FSM stays in s_done, with no RAM access, even if pac_block moves to a further pellet.
- reset=0 asserted during s_write -> ram_we=0 that cycle; next cycle score=0, pellets_left=PELLET_COUNT, state s_idle.
- Score preloaded so the next pellet overflows (binary, and BCD with `SCORE_BCD_EN`), POINTS=10 -> score saturates at 16'hFFFF binary, or 16'h9999 BCD.

Source files
------------

// File: rtl/pellet_eater.sv
// pellet_eater: clears pellets under pacman via RAM read-modify-write, keeps score and remaining count.
// Optional SCORE_BCD_EN: score kept as 4 packed BCD digits, saturating at 9999.
module pellet_eater #(
  parameter int PELLET_COUNT = 300,
  parameter int POINTS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [9:0]  pac_block,
  output logic [4:0]  ram_addr,
  input  logic [31:0] ram_rdata,
  output logic [31:0] ram_wdata,
  output logic        ram_we,
  output logic [15:0] score,
  output logic [9:0]  pellets_left,
  output logic        eat_pulse,
  output logic        level_clear,
  output logic        busy
);
  typedef enum logic [2:0] {s_idle, s_capture, s_read, s_wait, s_check, s_write, s_done} state_t;
  state_t state_q, state_d;
  logic [9:0] blk_q, blk_d, left_q, left_d;
  logic [4:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] score_q, score_d, score_sat;
  logic we_q, we_d, eat_q, eat_d, clear_q, clear_d, busy_q, busy_d, sel;
`ifdef SCORE_BCD_EN
  localparam logic [15:0] ADD = {8'd0, 4'(POINTS / 10), 4'(POINTS % 10)};
  logic [4:0] dsum [4];
  logic [4:0] carry;
  logic [15:0] bsum;
  always_comb begin
    carry[0] = 1'b0;
    bsum = '0;
    for (int i = 0; i < 4; i++) begin
      dsum[i] = {1'b0, score_q[4*i+:4]} + {1'b0, ADD[4*i+:4]} + {4'd0, carry[i]};
      carry[i+1] = dsum[i] > 5'd9;
      bsum[4*i+:4] = carry[i+1] ? dsum[i][3:0] + 4'd6 : dsum[i][3:0];
    end
    score_sat = carry[4] ? 16'h9999 : bsum;
  end
`else
  logic [16:0] bsum;
  assign bsum = {1'b0, score_q} + 17'(POINTS);
  assign score_sat = bsum[16] ? 16'hFFFF : bsum[15:0];
`endif
  assign sel = ram_rdata[~blk_q[4:0]];
  always_comb begin
    state_d = state_q;
    blk_d = blk_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    score_d = score_q;
    left_d = left_q;
    clear_d = clear_q;
    we_d = 1'b0;
    eat_d = 1'b0;
    case (state_q)
      s_idle: state_d = start ? s_capture : s_idle;
      s_capture: begin
        blk_d = pac_block;
        addr_d = pac_block[9:5];
        state_d = s_read;
      end
      s_read: state_d = s_wait;
      s_wait: state_d = s_check;
      s_check: begin
        we_d = sel;
        wdata_d = sel ? ram_rdata & ~(32'h8000_0000 >> blk_q[4:0]) : wdata_q;
        state_d = sel ? s_write : s_capture;
      end
      s_write: begin
        score_d = score_sat;
        left_d = left_q - 10'(left_q != 10'd0);
        eat_d = 1'b1;
        clear_d = clear_q | (left_q <= 10'd1);
        state_d = left_q <= 10'd1 ? s_done : s_capture;
      end
      default: state_d = s_done;
    endcase
    busy_d = state_d != s_idle && state_d != s_done;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= s_idle;
      blk_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      score_q <= '0;
      left_q <= 10'(PELLET_COUNT);
      we_q <= 1'b0;
      eat_q <= 1'b0;
      clear_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      blk_q <= blk_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      score_q <= score_d;
      left_q <= left_d;
      we_q <= we_d;
      eat_q <= eat_d;
      clear_q <= clear_d;
      busy_q <= busy_d;
    end
  end
  // a reset arriving during s_write must abort the write in that same cycle
  assign ram_we = we_q & reset;
  assign ram_addr = addr_q;
  assign ram_wdata = wdata_q;
  assign score = score_q;
  assign pellets_left = left_q;
  assign eat_pulse = eat_q;
  assign level_clear = clear_q;
  assign busy = busy_q;
endmodule
